// File: rtl/lookup_cfg_writer_if.sv
// Configuration word stream plus TCAM and action-RAM write channels of one lookup stage.
// master drives the config stream; slave is the cfg writer.
interface lookup_cfg_writer_if #(
    parameter int ENTRY_LEN = 1024,
    parameter int ACT_LEN   = 25
);
    logic [31:0]          cfg_tdata;
    logic                 cfg_tvalid;
    logic                 cfg_tlast;
    logic                 cfg_tready;
    logic [ENTRY_LEN-1:0] lookup_din;
    logic [ENTRY_LEN-1:0] lookup_din_mask;
    logic [3:0]           lookup_din_addr;
    logic                 lookup_din_en;
    logic [ACT_LEN-1:0]   action_data_in;
    logic [3:0]           action_addr;
    logic                 action_en;
    logic [7:0]           err_cnt;

    modport master (
        output cfg_tdata, cfg_tvalid, cfg_tlast,
        input  cfg_tready,
        input  lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_en,
        input  action_data_in, action_addr, action_en, err_cnt
    );

    modport slave (
        input  cfg_tdata, cfg_tvalid, cfg_tlast,
        output cfg_tready,
        output lookup_din, lookup_din_mask, lookup_din_addr, lookup_din_en,
        output action_data_in, action_addr, action_en, err_cnt
    );
endinterface

// File: rtl/lookup_cfg_writer.sv
// Stage-filtered config packet parser writing TCAM entry/mask pairs and action words.
// Strobe one cycle after the final payload beat; tready drops only during that write cycle.
module lookup_cfg_writer #(
    parameter logic [3:0] STAGE     = 4'd0,
    parameter int         ENTRY_LEN = 1024,
    parameter int         ACT_LEN   = 25
) (
    input  logic              axis_clk,
    input  logic              aresetn,
    lookup_cfg_writer_if.slave cfg
);
    localparam int W  = ENTRY_LEN / 32;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = $clog2(ENTRY_LEN);
    localparam logic [CW-1:0] WLAST = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, T_DATA, T_MASK, A_DATA, WRITE, DROP} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        wcnt;
    logic [ENTRY_LEN-1:0] data_stg, mask_stg, din_q, mask_q;
    logic [ACT_LEN-1:0]   act_stg, act_q;
    logic [3:0]           addr_stg, laddr_q, aaddr_q;
    logic                 is_tcam, last_seen;
    logic [7:0]           err_q;
    logic                 rdy, accept, err_inc, word_last, lookup_en, act_en;
    logic [3:0]           hdr_op, hdr_stage;
    logic [IW-1:0]        slot_lsb;

    assign hdr_op    = cfg.cfg_tdata[31:28];
    assign hdr_stage = cfg.cfg_tdata[27:24];
    assign accept    = cfg.cfg_tvalid & rdy;
    assign word_last = (wcnt == WLAST);
    // Word 0 of a payload lands in the top 32 bits of the staging register.
    assign slot_lsb  = IW'(WLAST - wcnt) << 5;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        rdy       = (state != WRITE);
        lookup_en = (state == WRITE) && is_tcam;
        act_en    = (state == WRITE) && !is_tcam;
        case (state)
            IDLE: if (accept) begin
                if (hdr_stage != STAGE) begin
                    state_nxt = cfg.cfg_tlast ? IDLE : DROP;
                end else if (hdr_op == 4'h1 || hdr_op == 4'h2) begin
                    if (cfg.cfg_tlast) begin
                        err_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = (hdr_op == 4'h1) ? T_DATA : A_DATA;
                    end
                end else begin
                    err_inc   = !cfg.cfg_tlast;
                    state_nxt = cfg.cfg_tlast ? IDLE : DROP;
                end
            end
            T_DATA: if (accept) begin
                if (cfg.cfg_tlast) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end else if (word_last) begin
                    state_nxt = T_MASK;
                end
            end
            T_MASK: if (accept) begin
                if (word_last) begin
                    state_nxt = WRITE;
                end else if (cfg.cfg_tlast) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            A_DATA: if (accept) state_nxt = WRITE;
            WRITE:  state_nxt = last_seen ? IDLE : DROP;
            DROP:   if (accept && cfg.cfg_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wcnt      <= '0;
            data_stg  <= '0;
            mask_stg  <= '0;
            act_stg   <= '0;
            addr_stg  <= '0;
            is_tcam   <= 1'b0;
            last_seen <= 1'b0;
            din_q     <= '0;
            mask_q    <= '0;
            laddr_q   <= '0;
            act_q     <= '0;
            aaddr_q   <= '0;
            err_q     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_stg <= cfg.cfg_tdata[3:0];
                    is_tcam  <= (hdr_op == 4'h1);
                    wcnt     <= '0;
                end
                T_DATA: if (accept) begin
                    data_stg[slot_lsb +: 32] <= cfg.cfg_tdata;
                    wcnt <= word_last ? '0 : wcnt + 1'b1;
                end
                T_MASK: if (accept) begin
                    mask_stg[slot_lsb +: 32] <= cfg.cfg_tdata;
                    wcnt      <= word_last ? '0 : wcnt + 1'b1;
                    last_seen <= cfg.cfg_tlast;
                end
                A_DATA: if (accept) begin
                    act_stg   <= cfg.cfg_tdata[ACT_LEN-1:0];
                    last_seen <= cfg.cfg_tlast;
                end
                WRITE: begin
                    if (is_tcam) begin
                        din_q   <= data_stg;
                        mask_q  <= mask_stg;
                        laddr_q <= addr_stg;
                    end else begin
                        act_q   <= act_stg;
                        aaddr_q <= addr_stg;
                    end
                end
                default: ;
            endcase
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    // Buses show the staged value during the write cycle, then the latched copy holds it.
    assign cfg.cfg_tready      = rdy;
    assign cfg.lookup_din_en   = lookup_en;
    assign cfg.action_en       = act_en;
    assign cfg.lookup_din      = lookup_en ? data_stg : din_q;
    assign cfg.lookup_din_mask = lookup_en ? mask_stg : mask_q;
    assign cfg.lookup_din_addr = lookup_en ? addr_stg : laddr_q;
    assign cfg.action_data_in  = act_en ? act_stg : act_q;
    assign cfg.action_addr     = act_en ? addr_stg : aaddr_q;
    assign cfg.err_cnt         = err_q;
endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Directed packet bench for lookup_cfg_writer with a packet-level reference model.
module tb_lookup_cfg_writer;
    localparam int E = 1024;
    localparam int W = E / 32;
    localparam int A = 25;
    localparam logic [3:0] STG = 4'd0;

    logic axis_clk = 1'b0;
    logic aresetn  = 1'b1;
    always #5 axis_clk = ~axis_clk;

    lookup_cfg_writer_if #(.ENTRY_LEN(E), .ACT_LEN(A)) bus();

    lookup_cfg_writer #(.STAGE(STG), .ENTRY_LEN(E), .ACT_LEN(A)) dut (
        .axis_clk (axis_clk),
        .aresetn  (aresetn),
        .cfg      (bus)
    );

    typedef struct {
        int           cyc;
        int           kind;   // 1 tcam write, 2 action write, 3 error
        logic [E-1:0] data;
        logic [E-1:0] mask;
        logic [3:0]   addr;
        logic [A-1:0] act;
    } ev_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    ev_t          evq[$];
    ev_t          ev;
    logic [31:0]  pkt[$];
    logic [E-1:0] x_din = '0, x_mask = '0;
    logic [3:0]   x_laddr = '0, x_aaddr = '0;
    logic [A-1:0] x_act = '0;
    logic [7:0]   x_err = '0;
    int           cur_kind;
    int           n_lpulse = 0, n_apulse = 0;

    int           m_kind, m_sidx, m_eidx;
    logic [E-1:0] m_data, m_mask;
    logic [3:0]   m_addr;
    logic [A-1:0] m_act;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [E-1:0] a, input logic [E-1:0] e);
        int idx;
        idx = -1;
        checks++;
        if (a !== e) begin
            failures++;
            for (int j = W - 1; j >= 0; j--)
                if (idx < 0 && a[j*32 +: 32] !== e[j*32 +: 32]) idx = j;
            $display("FAIL %s: word %0d got %08h want %08h (t=%0t)",
                     nm, idx, a[idx*32 +: 32], e[idx*32 +: 32], $time);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [3:0] op, input logic [3:0] st, input logic [3:0] ad);
        return {op, st, 20'h0, ad};
    endfunction

    // Packet-level outcome: which beat triggers a write or an error, and the write contents.
    task automatic model_pkt();
        int n, need;
        logic [3:0] op, st;
        n  = pkt.size();
        op = pkt[0][31:28];
        st = pkt[0][27:24];
        m_kind = 0; m_sidx = -1; m_eidx = -1;
        m_data = '0; m_mask = '0; m_act = '0;
        m_addr = pkt[0][3:0];
        if (st == STG) begin
            if (op == 4'h1 || op == 4'h2) begin
                need = (op == 4'h1) ? 1 + 2 * W : 2;
                if (n < need) m_eidx = n - 1;
                else begin
                    m_kind = int'(op);
                    m_sidx = need - 1;
                    if (op == 4'h1) begin
                        for (int j = 0; j < W; j++) begin
                            m_data = {m_data[E-33:0], pkt[1 + j]};
                            m_mask = {m_mask[E-33:0], pkt[1 + W + j]};
                        end
                    end else begin
                        m_act = pkt[1][A-1:0];
                    end
                end
            end else if (n > 1) begin
                m_eidx = 0;
            end
        end
    endtask

    task automatic schedule(input int k);
        ev_t e;
        e.cyc = cyc + 1; e.data = m_data; e.mask = m_mask; e.addr = m_addr; e.act = m_act;
        if (k == m_sidx) begin e.kind = m_kind; evq.push_back(e); end
        if (k == m_eidx) begin e.kind = 3; evq.push_back(e); end
    endtask

    task automatic send(input int gap_every, input bit modelled);
        int tries;
        bit done;
        if (modelled) model_pkt();
        for (int k = 0; k < pkt.size(); k++) begin
            if (gap_every > 0 && k > 0 && (k % gap_every) == 0)
                repeat (2) begin @(negedge axis_clk); bus.cfg_tvalid = 1'b0; end
            tries = 0; done = 1'b0;
            while (!done) begin
                @(negedge axis_clk);
                bus.cfg_tvalid = 1'b1;
                bus.cfg_tdata  = pkt[k];
                bus.cfg_tlast  = modelled && (k == pkt.size() - 1);
                if (bus.cfg_tready) begin
                    done = 1'b1;
                    if (modelled) schedule(k);
                end else if (++tries > 4) begin
                    checks++; failures++;
                    $display("FAIL tready_timeout: got 0 want 1 at beat %0d", k);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge axis_clk); bus.cfg_tvalid = 1'b0; bus.cfg_tlast = 1'b0; end
    endtask

    task automatic do_reset();
        @(negedge axis_clk);
        bus.cfg_tvalid = 1'b0; bus.cfg_tlast = 1'b0;
        #2 aresetn = 1'b0;
        evq.delete();
        x_din = '0; x_mask = '0; x_laddr = '0; x_aaddr = '0; x_act = '0; x_err = '0;
        #1;
        chk("rst_din_or", 64'(|bus.lookup_din), 0);
        chk("rst_small", {bus.lookup_din_en, bus.action_en, bus.lookup_din_addr,
                          bus.action_addr, bus.err_cnt}, 0);
        repeat (2) @(negedge axis_clk);
        #2 aresetn = 1'b1;
    endtask

    always @(negedge axis_clk) begin
        if (!aresetn) begin
            chk("reset_zero", 64'(|{bus.lookup_din, bus.lookup_din_mask, bus.lookup_din_addr,
                bus.lookup_din_en, bus.action_data_in, bus.action_addr, bus.action_en,
                bus.err_cnt}), 0);
        end else begin
            cur_kind = 0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                ev = evq.pop_front();
                if (ev.kind == 3) x_err = (x_err == 8'hFF) ? 8'hFF : x_err + 8'd1;
                else if (ev.kind == 1) begin
                    cur_kind = 1; x_din = ev.data; x_mask = ev.mask; x_laddr = ev.addr;
                end else begin
                    cur_kind = 2; x_act = ev.act; x_aaddr = ev.addr;
                end
            end
            chk("strobe_ready", {bus.lookup_din_en, bus.action_en, bus.cfg_tready},
                {cur_kind == 1, cur_kind == 2, cur_kind == 0});
            chk_wide("lookup_din", bus.lookup_din, x_din);
            chk_wide("lookup_din_mask", bus.lookup_din_mask, x_mask);
            chk("addr_act_err", {bus.lookup_din_addr, bus.action_addr, bus.action_data_in, bus.err_cnt},
                {x_laddr, x_aaddr, x_act, x_err});
            if (bus.lookup_din_en) n_lpulse++;
            if (bus.action_en) n_apulse++;
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_tvalid = 1'b0; bus.cfg_tlast = 1'b0; bus.cfg_tdata = '0;
        #1 aresetn = 1'b0;
        repeat (2) @(negedge axis_clk);
        chk("init_small", {bus.lookup_din_en, bus.action_en, bus.err_cnt, bus.action_data_in}, 0);
        chk("init_din_or", 64'(|bus.lookup_din), 0);
        #2 aresetn = 1'b1;
        idle(2);

        // action write
        pkt = '{hdr(4'h2, 4'h0, 4'h5), 32'h01ABCDE};
        send(0, 1); idle(3);
        chk("act_addr_lit", bus.action_addr, 5);
        chk("act_data_lit", bus.action_data_in, 25'h1ABCDE);

        // TCAM write with tvalid gaps
        pkt.delete(); pkt.push_back(hdr(4'h1, 4'h0, 4'hA));
        for (int i = 0; i < W; i++) pkt.push_back(32'(i));
        for (int i = 0; i < W; i++) pkt.push_back(~32'(i));
        send(7, 1); idle(3);
        chk("tcam_top_lit", bus.lookup_din[E-1 -: 32], 0);
        chk("tcam_low_lit", bus.lookup_din[31:0], 31);
        chk("tcam_mask_lit", bus.lookup_din_mask[31:0], 32'hFFFF_FFE0);
        chk("tcam_addr_lit", bus.lookup_din_addr, 10);
        chk("tcam_pulse_lit", n_lpulse, 1);

        // other stage, then an action packet straight after
        pkt.delete(); pkt.push_back(hdr(4'h1, 4'h3, 4'h2));
        for (int i = 0; i < 2 * W; i++) pkt.push_back(32'(i + 100));
        send(0, 1);
        pkt = '{hdr(4'h2, 4'h0, 4'h9), 32'hFFFF_FFFF};
        send(0, 1); idle(3);
        chk("filter_err_lit", bus.err_cnt, 0);
        chk("filter_next_lit", bus.action_data_in, 25'h1FF_FFFF);

        // bad opcode
        pkt = '{hdr(4'h7, 4'h0, 4'h1), 32'h1234, 32'h5678};
        send(0, 1); idle(2);
        chk("badop_err_lit", bus.err_cnt, 1);

        // TCAM cut short after 10 payload words
        pkt.delete(); pkt.push_back(hdr(4'h1, 4'h0, 4'h3));
        for (int i = 0; i < 10; i++) pkt.push_back(32'hDEAD_0000 + 32'(i));
        send(0, 1); idle(2);
        chk("early_err_lit", bus.err_cnt, 2);
        chk("early_hold_lit", {bus.lookup_din_addr, bus.lookup_din[31:0]}, {4'hA, 32'd31});

        // trailing words after a complete action payload
        pkt = '{hdr(4'h2, 4'h0, 4'h7), 32'h0000123, 32'hAAAA, 32'hBBBB, 32'hCCCC};
        send(0, 1); idle(2);
        chk("trail_err_lit", bus.err_cnt, 2);
        chk("trail_pulse_lit", n_apulse, 3);

        // back-to-back TCAM packets
        for (int p = 0; p < 2; p++) begin
            pkt.delete(); pkt.push_back(hdr(4'h1, 4'h0, 4'(14 + p)));
            for (int i = 0; i < W; i++) pkt.push_back(32'(i * 3 + 1 + p * 1000));
            for (int i = 0; i < W; i++) pkt.push_back(32'(i) ^ 32'hA5A5_5A5A);
            send(0, 1);
        end
        idle(3);

        // header-only packets
        pkt = '{hdr(4'h1, 4'h0, 4'h2)}; send(0, 1);
        pkt = '{hdr(4'h1, 4'h5, 4'h2)}; send(0, 1);
        pkt = '{hdr(4'h7, 4'h0, 4'h2)}; send(0, 1);
        idle(2);
        chk("hdr_last_err_lit", bus.err_cnt, 3);

        // reset in the middle of a TCAM payload, then an action packet with gaps
        pkt.delete(); pkt.push_back(hdr(4'h1, 4'h0, 4'h6));
        for (int i = 0; i < 20; i++) pkt.push_back(32'hF00D_0000 + 32'(i));
        send(0, 0);
        do_reset();
        idle(1);
        pkt = '{hdr(4'h2, 4'h0, 4'h4), 32'h0ABC123};
        send(1, 1); idle(3);
        chk("post_rst_act_lit", {bus.action_addr, bus.action_data_in}, {4'h4, 25'hABC123});
        chk("post_rst_din_lit", 64'(|bus.lookup_din), 0);

        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            pkt = '{hdr(4'h2, 4'h0, 4'h1)};
            send(0, 1);
        end
        idle(3);
        chk("sat_err_lit", bus.err_cnt, 8'hFF);

        idle(3);
        chk("events_drained", evq.size(), 0);
        chk("lookup_pulses_lit", n_lpulse, 3);
        chk("action_pulses_lit", n_apulse, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
